// File: rtl/fp_align_unpack.sv
// fp_align_unpack: unpacks two IEEE-754 single-precision operands, orders them
// by magnitude, aligns the smaller one with a serial right shifter that keeps a
// sticky bit, and returns two's-complement mantissas ready for the rounding adder.
//
// Ports:
//   clk, rst_n          clock, synchronous active-low reset
//   in_valid/in_ready   operand handshake (in_ready high only when idle)
//   a, b                IEEE single operands
//   out_valid/out_ready result handshake (result held until accepted)
//   large_n, small_n    26-bit two's-complement {sign, hidden, frac, guard}
//   bit_r               sticky OR of bits shifted below the guard position
//   e_out               effective biased exponent of the larger operand
module fp_align_unpack #(
  parameter int unsigned SHIFT_SAT = 26,
  parameter int unsigned MAN_W     = 23
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [25:0] large_n,
  output logic [25:0] small_n,
  output logic        bit_r,
  output logic [7:0]  e_out
);

  localparam int unsigned EXP_W = 8;
  localparam int unsigned MAG_W = MAN_W + 3;
  localparam int unsigned CNT_W = $clog2(SHIFT_SAT + 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CMP   = 3'd1,
    SHIFT = 3'd2,
    NEG   = 3'd3,
    DONE  = 3'd4
  } state_t;

  state_t             state;
  logic [31:0]        a_r;
  logic [31:0]        b_r;
  logic [MAG_W-1:0]   large_mag;
  logic [MAG_W-1:0]   small_mag;
  logic               sign_l;
  logic               sign_s;
  logic [EXP_W-1:0]   e_l;
  logic [CNT_W-1:0]   cnt;
  logic               sticky;

  // Unpack captured operands and decide ordering and shift distance.
  logic [EXP_W-1:0] exp_a, exp_b, eff_a, eff_b, e_big, e_lit, diff;
  logic [MAN_W-1:0] frac_a, frac_b;
  logic [MAG_W-1:0] mag_a, mag_b;
  logic             a_large;
  logic [CNT_W-1:0] shift_d;

  assign exp_a  = a_r[30:MAN_W];
  assign exp_b  = b_r[30:MAN_W];
  assign frac_a = a_r[MAN_W-1:0];
  assign frac_b = b_r[MAN_W-1:0];
  // Denormals and zeros behave as exponent 1 with no hidden bit.
  assign eff_a  = (exp_a == '0) ? EXP_W'(1) : exp_a;
  assign eff_b  = (exp_b == '0) ? EXP_W'(1) : exp_b;
  assign mag_a  = {1'b0, |exp_a, frac_a, 1'b0};
  assign mag_b  = {1'b0, |exp_b, frac_b, 1'b0};
  // Strict compare: an exact tie selects B as the large operand.
  assign a_large = {eff_a, frac_a} > {eff_b, frac_b};
  assign e_big   = a_large ? eff_a : eff_b;
  assign e_lit   = a_large ? eff_b : eff_a;
  assign diff    = e_big - e_lit;
  assign shift_d = (32'(diff) > SHIFT_SAT) ? CNT_W'(SHIFT_SAT) : CNT_W'(diff);

  // Control FSM and datapath registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
      large_n   <= '0;
      small_n   <= '0;
      bit_r     <= 1'b0;
      e_out     <= '0;
      a_r       <= '0;
      b_r       <= '0;
      large_mag <= '0;
      small_mag <= '0;
      sign_l    <= 1'b0;
      sign_s    <= 1'b0;
      e_l       <= '0;
      cnt       <= '0;
      sticky    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid && in_ready) begin
            a_r      <= a;
            b_r      <= b;
            in_ready <= 1'b0;
            state    <= CMP;
          end else begin
            in_ready <= 1'b1;
          end
        end
        CMP: begin
          large_mag <= a_large ? mag_a : mag_b;
          small_mag <= a_large ? mag_b : mag_a;
          sign_l    <= a_large ? a_r[31] : b_r[31];
          sign_s    <= a_large ? b_r[31] : a_r[31];
          e_l       <= e_big;
          cnt       <= shift_d;
          sticky    <= 1'b0;
          state     <= (shift_d == '0) ? NEG : SHIFT;
        end
        SHIFT: begin
          small_mag <= small_mag >> 1;
          sticky    <= sticky | small_mag[0];
          cnt       <= cnt - CNT_W'(1);
          if (cnt == CNT_W'(1)) begin
            state <= NEG;
          end
        end
        NEG: begin
          // Negating a zero magnitude wraps to zero mod 2^26.
          large_n   <= sign_l ? (MAG_W'(0) - large_mag) : large_mag;
          small_n   <= sign_s ? (MAG_W'(0) - small_mag) : small_mag;
          bit_r     <= sticky;
          e_out     <= e_l;
          out_valid <= 1'b1;
          state     <= DONE;
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fp_align_unpack.sv
// Scoreboard bench for fp_align_unpack: directed cases plus randomized operands
// checked against an arithmetic reference model, including latency.
module tb_fp_align_unpack;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [25:0] large_n;
  logic [25:0] small_n;
  logic        bit_r;
  logic [7:0]  e_out;

  always #5 clk = ~clk;

  fp_align_unpack dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .large_n   (large_n),
    .small_n   (small_n),
    .bit_r     (bit_r),
    .e_out     (e_out)
  );

  typedef struct {
    logic [25:0] ln;
    logic [25:0] sn;
    logic        br;
    logic [7:0]  e;
    longint      lat;
    longint      acc;
  } exp_t;

  exp_t   sb[$];
  int     checks = 0;
  int     failures = 0;
  longint cyc = 0;
  bit     auto_rdy = 1'b1;
  bit     hold_rdy = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input longint act, input longint expv);
    checks++;
    if (act !== expv) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", nm, act, expv, cyc);
    end
  endtask

  // Reference model: plain integer arithmetic on magnitudes.
  function automatic exp_t model(input logic [31:0] x, input logic [31:0] y);
    exp_t r;
    longint unsigned ex, ey, fx, fy, efx, efy, mx, my, ml, ms, el, es, d, p;
    bit sx, sy, sl, ss, x_large;
    ex = x[30:23]; ey = y[30:23];
    fx = x[22:0];  fy = y[22:0];
    sx = x[31];    sy = y[31];
    efx = (ex == 0) ? 1 : ex;
    efy = (ey == 0) ? 1 : ey;
    mx = ((ex != 0) ? (64'd1 << 24) : 64'd0) + fx * 2;
    my = ((ey != 0) ? (64'd1 << 24) : 64'd0) + fy * 2;
    x_large = (efx > efy) || ((efx == efy) && (fx > fy));
    if (x_large) begin
      ml = mx; ms = my; el = efx; es = efy; sl = sx; ss = sy;
    end else begin
      ml = my; ms = mx; el = efy; es = efx; sl = sy; ss = sx;
    end
    d = el - es;
    if (d > 26) d = 26;
    p = 64'd1 << d;
    r.ln  = sl ? 26'((64'd1 << 26) - ml) : 26'(ml);
    r.sn  = ss ? 26'((64'd1 << 26) - (ms / p)) : 26'(ms / p);
    r.br  = (ms % p) != 0;
    r.e   = 8'(el);
    r.lat = longint'(2 + d);
    r.acc = 0;
    return r;
  endfunction

  function automatic exp_t mk(input logic [25:0] ln, input logic [25:0] sn,
                              input logic br, input logic [7:0] e, input longint lat);
    exp_t r;
    r.ln = ln; r.sn = sn; r.br = br; r.e = e; r.lat = lat; r.acc = 0;
    return r;
  endfunction

  // out_ready driver: held low, always high, or random.
  always @(posedge clk) begin
    #2;
    if (hold_rdy)      out_ready = 1'b0;
    else if (auto_rdy) out_ready = 1'b1;
    else               out_ready = ($urandom_range(0, 3) != 0);
  end

  // Monitor: pop on first sight of each result, then check it every cycle it is held.
  exp_t cur;
  bit   have = 1'b0;
  always @(negedge clk) begin
    if (!rst_n) begin
      have = 1'b0;
    end else if (out_valid) begin
      if (!have) begin
        have = 1'b1;
        if (sb.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_out_valid: got out_valid=1 expected no pending result at cycle %0d", cyc);
          cur = mk('0, '0, 1'b0, '0, 0);
        end else begin
          cur = sb.pop_front();
          chk("latency", cyc - cur.acc, cur.lat);
        end
      end
      chk("large_n", large_n, cur.ln);
      chk("small_n", small_n, cur.sn);
      chk("bit_r", bit_r, cur.br);
      chk("e_out", e_out, cur.e);
      if (out_ready) have = 1'b0;
    end
  end

  task automatic send(input logic [31:0] aa, input logic [31:0] bb, input exp_t e);
    int n;
    @(posedge clk); #2;
    a = aa; b = bb; in_valid = 1'b1;
    n = 0;
    forever begin
      @(negedge clk);
      if (in_ready) break;
      n++;
      if (n > 300) begin
        chk("accept_timeout", 0, 1);
        in_valid = 1'b0;
        return;
      end
    end
    e.acc = cyc + 1;
    sb.push_back(e);
    @(posedge clk); #2;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    forever begin
      @(negedge clk);
      if (sb.size() == 0 && !out_valid && in_ready) break;
      n++;
      if (n > 500) begin
        chk("drain_timeout", 0, 1);
        return;
      end
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no finish expected end of test");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] ra, rb;
    int          eb;
    int          n;

    // Reset state.
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_large_n", large_n, 0);
    chk("rst_small_n", small_n, 0);
    chk("rst_bit_r", bit_r, 0);
    chk("rst_e_out", e_out, 0);
    @(posedge clk); #1 rst_n = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("idle_in_ready", in_ready, 1);

    // Directed cases.
    send(32'h3F800000, 32'h3F800000, mk(26'h1000000, 26'h1000000, 1'b0, 8'h7F, 2));
    send(32'h40000000, 32'hBF800000, mk(26'h1000000, 26'h3800000, 1'b0, 8'h80, 3));
    send(32'h3F800001, 32'h40800000, mk(26'h1000000, 26'h0400000, 1'b1, 8'h81, 4));
    send(32'h4F800000, 32'h3F800001, mk(26'h1000000, 26'h0000000, 1'b1, 8'h9F, 28));
    send(32'h00000000, 32'h40000000, model(32'h00000000, 32'h40000000));
    send(32'h80000000, 32'h80000000, model(32'h80000000, 32'h80000000));
    send(32'h00000003, 32'h80000001, model(32'h00000003, 32'h80000001));
    drain();

    // Backpressure with in_valid held high.
    hold_rdy = 1'b1;
    send(32'h40000000, 32'hBF800000, mk(26'h1000000, 26'h3800000, 1'b0, 8'h80, 3));
    @(posedge clk); #2;
    a = 32'h3F800000; b = 32'h3F800000; in_valid = 1'b1;
    n = 0;
    while (!out_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("bp_out_valid_seen", out_valid, 1);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("bp_in_ready", in_ready, 0);
      chk("bp_out_valid", out_valid, 1);
    end
    @(posedge clk); #1;
    hold_rdy = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("bp_release_out_valid", out_valid, 0);
    chk("bp_release_in_ready", in_ready, 1);
    drain();

    // Reset in the middle of a long shift.
    send(32'h4F800000, 32'h3F800001, mk(26'h1000000, 26'h0000000, 1'b1, 8'h9F, 28));
    repeat (5) @(negedge clk);
    @(posedge clk); #1;
    rst_n = 1'b0;
    sb.delete();
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_large_n", large_n, 0);
    chk("midrst_small_n", small_n, 0);
    chk("midrst_bit_r", bit_r, 0);
    chk("midrst_e_out", e_out, 0);
    @(negedge clk);
    chk("midrst_in_ready", in_ready, 1);
    send(32'h3F800000, 32'h3F800000, mk(26'h1000000, 26'h1000000, 1'b0, 8'h7F, 2));
    drain();

    // Randomized operands with random backpressure.
    auto_rdy = 1'b0;
    for (int k = 0; k < 40; k++) begin
      ra = $urandom();
      eb = int'(ra[30:23]) + int'($urandom_range(0, 60)) - 30;
      if (eb < 0) eb = 0;
      if (eb > 255) eb = 255;
      rb = {1'($urandom_range(0, 1)), 8'(eb), 23'($urandom())};
      case ($urandom_range(0, 7))
        0: rb = {~ra[31], ra[30:0]};
        1: rb = {rb[31], 31'h0};
        2: ra = {ra[31], 8'h00, ra[22:0]};
        default: ;
      endcase
      if ($urandom_range(0, 1) == 1) send(ra, rb, model(ra, rb));
      else                           send(rb, ra, model(rb, ra));
    end
    auto_rdy = 1'b1;
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
